// File: rtl/man_decoder.sv
// man_decoder: Manchester receiver for one PRE_W-bit-preamble + DATA_W-bit frame (MSB first), open-loop timed from the first mid-bit rise.
// Ports: _clk/_rst (sync, active-high); _en arms the receiver (low aborts a frame); _input_wire Manchester line;
//   _divide_freq D with half-bit period H = max(D,3)+1, sampled at frame start; _output_reg decoded byte, held;
//   _valid one-cycle frame-complete pulse; _err coding/preamble violation, qualified by _valid; _busy while receiving.
// Build option MAN_DEC_SYNC_EN: adds a 2-flop synchronizer ahead of the line sample register.
module man_decoder #(
  parameter int DATA_W = 8,
  parameter int PRE_W  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              _clk,
  input  logic              _rst,
  input  logic              _en,
  input  logic              _input_wire,
  input  logic [CNT_W-1:0]  _divide_freq,
  output logic [DATA_W-1:0] _output_reg,
  output logic              _valid,
  output logic              _err,
  output logic              _busy
);
  localparam int NB = DATA_W + PRE_W - 1;
  localparam int KW = $clog2(NB + 1);
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  state_t state_q, state_d;
  logic line_in, line_q, line_p_q, start;
  logic [CNT_W-1:0] hd, qd, t_q, t_d, tgt_q, tgt_d, step_a_q, step_a_d, step_b_q, step_b_d;
  logic [KW-1:0] k_q, k_d;
  logic ph_q, ph_d, a_q, a_d, err_q, err_d, eo_q, eo_d;
  logic [DATA_W-1:0] sh_q, sh_d, out_q, out_d;
`ifdef MAN_DEC_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge _clk) sync_q <= _rst ? 2'b00 : {sync_q[0], _input_wire};
  assign line_in = sync_q[1];
`else
  assign line_in = _input_wire;
`endif
  assign start       = line_q & ~line_p_q & _en;
  assign _valid      = state_q == DONE;
  assign _busy       = state_q == RECV || (state_q == IDLE && start);
  assign _output_reg = out_q;
  assign _err        = eo_q;
  // t counts clocks since the start edge; tgt_q is the next sample time, alternating
  // A (bit value) and B (must be the complement), stepping by 2q then 2H-2q.
  always_comb begin
    hd = (_divide_freq < CNT_W'(3) ? CNT_W'(3) : _divide_freq) + CNT_W'(1);
    qd = hd >> 1;
    state_d = state_q;
    t_d = t_q + CNT_W'(1);
    tgt_d = tgt_q;
    step_a_d = step_a_q;
    step_b_d = step_b_q;
    k_d = k_q;
    ph_d = ph_q;
    a_d = a_q;
    err_d = err_q;
    sh_d = sh_q;
    out_d = out_q;
    eo_d = eo_q;
    if (state_q == IDLE && start) begin
      state_d = RECV;
      t_d = CNT_W'(1);
      tgt_d = (hd << 1) - qd;
      step_a_d = qd << 1;
      step_b_d = (hd << 1) - (qd << 1);
      k_d = KW'(1);
      ph_d = 1'b0;
      err_d = 1'b0;
    end else if (state_q == RECV) begin
      if (!_en) state_d = IDLE;
      else if (t_q == tgt_q && !ph_q) begin
        a_d = line_q;
        ph_d = 1'b1;
        tgt_d = tgt_q + step_a_q;
        if (k_q < KW'(PRE_W)) err_d = err_q | line_q;
        else sh_d = {sh_q[DATA_W-2:0], line_q};
      end else if (t_q == tgt_q) begin
        err_d = err_q | (line_q == a_q);
        ph_d = 1'b0;
        tgt_d = tgt_q + step_b_q;
        k_d = k_q + KW'(1);
        if (k_q == KW'(NB)) begin
          state_d = DONE;
          out_d = sh_q;
          eo_d = err_d;
        end
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge _clk) begin
    if (_rst) begin
      state_q <= IDLE;
      line_q <= 1'b0;
      line_p_q <= 1'b0;
      t_q <= '0;
      tgt_q <= '0;
      step_a_q <= '0;
      step_b_q <= '0;
      k_q <= '0;
      ph_q <= 1'b0;
      a_q <= 1'b0;
      err_q <= 1'b0;
      sh_q <= '0;
      out_q <= '0;
      eo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q <= line_in;
      line_p_q <= line_q;
      t_q <= t_d;
      tgt_q <= tgt_d;
      step_a_q <= step_a_d;
      step_b_q <= step_b_d;
      k_q <= k_d;
      ph_q <= ph_d;
      a_q <= a_d;
      err_q <= err_d;
      sh_q <= sh_d;
      out_q <= out_d;
      eo_q <= eo_d;
    end
  end
endmodule

// File: tb/tb_man_decoder.sv
// tb_man_decoder: directed self-checking bench for man_decoder with an on-clock Manchester encoder model.
module tb_man_decoder;
  logic clk = 0, rst = 1, en = 1, din = 0;
  logic [31:0] dfreq = 32'd5;
  logic [7:0] dout;
  logic valid, err, busy;
  int cyc = 0, tests = 0, fails = 0, nbusy = 0;
  int v_cyc[$];
  logic [7:0] v_out[$];
  logic v_err[$];
`ifdef MAN_DEC_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  man_decoder dut (._clk(clk), ._rst(rst), ._en(en), ._input_wire(din), ._divide_freq(dfreq),
                   ._output_reg(dout), ._valid(valid), ._err(err), ._busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_out.push_back(dout);
      v_err.push_back(err);
    end
    if (busy) nbusy++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Encoder: each bit is first half = bit, second half = ~bit; bit 'bad' keeps its first half level.
  task automatic send(input logic [9:0] bits, input int h, input int bad, output int rise);
    rise = 0;
    for (int b = 9; b >= 0; b--) begin
      din = bits[b];
      tick(h);
      if (b == 9) rise = cyc;
      din = (b == bad) ? bits[b] : ~bits[b];
      tick(h);
    end
    din = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    tick(3);
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_out got=%h exp=00", dout); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", valid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 0;
    tick(3);
  endtask
  task automatic test_single;
    int b0 = v_cyc.size(), nb0 = nbusy, r;
    send(10'h0A5, 6, -1, r);
    tick(10);
    tests++; if (v_cyc.size() !== b0 + 1) begin fails++; $display("FAIL a5_count got=%0d exp=%0d", v_cyc.size() - b0, 1); end
    if (v_cyc.size() > b0) begin
      tests++; if (v_cyc[b0] !== r + 113 + SD) begin fails++; $display("FAIL a5_latency got=%0d exp=%0d", v_cyc[b0] - r - 1 - SD, 112); end
      tests++; if (v_out[b0] !== 8'hA5) begin fails++; $display("FAIL a5_out got=%h exp=a5", v_out[b0]); end
      tests++; if (v_err[b0] !== 1'b0) begin fails++; $display("FAIL a5_err got=%b exp=0", v_err[b0]); end
    end
    tests++; if (nbusy - nb0 !== 112) begin fails++; $display("FAIL a5_busy_cycles got=%0d exp=112", nbusy - nb0); end
  endtask
  task automatic test_back_to_back;
    int b0 = v_cyc.size(), r1, r2;
    send(10'h000, 6, -1, r1);
    tick(10);
    send(10'h0FF, 6, -1, r2);
    tick(10);
    tests++; if (v_cyc.size() !== b0 + 2) begin fails++; $display("FAIL b2b_count got=%0d exp=2", v_cyc.size() - b0); end
    if (v_cyc.size() > b0 + 1) begin
      tests++; if (v_out[b0] !== 8'h00) begin fails++; $display("FAIL b2b_out0 got=%h exp=00", v_out[b0]); end
      tests++; if (v_err[b0] !== 1'b0) begin fails++; $display("FAIL b2b_err0 got=%b exp=0", v_err[b0]); end
      tests++; if (v_out[b0+1] !== 8'hFF) begin fails++; $display("FAIL b2b_out1 got=%h exp=ff", v_out[b0+1]); end
      tests++; if (v_err[b0+1] !== 1'b0) begin fails++; $display("FAIL b2b_err1 got=%b exp=0", v_err[b0+1]); end
      tests++; if (v_cyc[b0+1] !== r2 + 113 + SD) begin fails++; $display("FAIL b2b_latency1 got=%0d exp=%0d", v_cyc[b0+1], r2 + 113 + SD); end
    end
  endtask
  task automatic test_coding_err;
    int b0 = v_cyc.size(), r;
    fork
      send(10'h03C, 6, 3, r);
      begin tick(20); dfreq = 32'd40; end
    join
    dfreq = 32'd5;
    tick(10);
    tests++; if (v_cyc.size() !== b0 + 1) begin fails++; $display("FAIL code_count got=%0d exp=1", v_cyc.size() - b0); end
    if (v_cyc.size() > b0) begin
      tests++; if (v_out[b0] !== 8'h3C) begin fails++; $display("FAIL code_out got=%h exp=3c", v_out[b0]); end
      tests++; if (v_err[b0] !== 1'b1) begin fails++; $display("FAIL code_err got=%b exp=1", v_err[b0]); end
      tests++; if (v_cyc[b0] !== r + 113 + SD) begin fails++; $display("FAIL code_latency got=%0d exp=%0d", v_cyc[b0], r + 113 + SD); end
    end
  endtask
  task automatic test_preamble;
    int b0 = v_cyc.size(), r;
    send(10'h112, 6, -1, r);
    tick(10);
    tests++; if (v_cyc.size() !== b0 + 1) begin fails++; $display("FAIL pre_count got=%0d exp=1", v_cyc.size() - b0); end
    if (v_cyc.size() > b0) begin
      tests++; if (v_out[b0] !== 8'h12) begin fails++; $display("FAIL pre_out got=%h exp=12", v_out[b0]); end
      tests++; if (v_err[b0] !== 1'b1) begin fails++; $display("FAIL pre_err got=%b exp=1", v_err[b0]); end
    end
  endtask
  task automatic test_abort_en;
    int b0 = v_cyc.size(), r;
    fork
      send(10'h077, 6, -1, r);
      begin
        tick(6 + 1 + SD + 50);
        en = 0;
        tick(1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_en_busy got=%b exp=0", busy); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_en_valid got=%b exp=0", valid); end
      end
    join
    en = 1;
    tick(10);
    tests++; if (v_cyc.size() !== b0) begin fails++; $display("FAIL abort_en_count got=%0d exp=0", v_cyc.size() - b0); end
    send(10'h081, 6, -1, r);
    tick(10);
    tests++; if (v_cyc.size() !== b0 + 1) begin fails++; $display("FAIL after_abort_count got=%0d exp=1", v_cyc.size() - b0); end
    if (v_cyc.size() > b0) begin
      tests++; if (v_out[b0] !== 8'h81) begin fails++; $display("FAIL after_abort_out got=%h exp=81", v_out[b0]); end
      tests++; if (v_err[b0] !== 1'b0) begin fails++; $display("FAIL after_abort_err got=%b exp=0", v_err[b0]); end
    end
  endtask
  task automatic test_abort_rst;
    int b0 = v_cyc.size(), r;
    fork
      send(10'h077, 6, -1, r);
      begin
        tick(6 + 1 + SD + 50);
        rst = 1;
        tick(1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_rst_busy got=%b exp=0", busy); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_rst_valid got=%b exp=0", valid); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL abort_rst_out got=%h exp=00", dout); end
      end
    join
    rst = 0;
    tick(10);
    tests++; if (v_cyc.size() !== b0) begin fails++; $display("FAIL abort_rst_count got=%0d exp=0", v_cyc.size() - b0); end
  endtask
  task automatic test_en_line_high;
    int b0 = v_cyc.size();
    en = 0;
    din = 1;
    tick(8);
    en = 1;
    tick(8);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL en_high_busy got=%b exp=0", busy); end
    din = 0;
    tick(130);
    tests++; if (v_cyc.size() !== b0) begin fails++; $display("FAIL en_high_count got=%0d exp=0", v_cyc.size() - b0); end
  endtask
  task automatic test_clamp;
    int b0 = v_cyc.size(), r;
    dfreq = 32'd1;
    send(10'h0C3, 4, -1, r);
    tick(10);
    dfreq = 32'd5;
    tests++; if (v_cyc.size() !== b0 + 1) begin fails++; $display("FAIL clamp_count got=%0d exp=1", v_cyc.size() - b0); end
    if (v_cyc.size() > b0) begin
      tests++; if (v_out[b0] !== 8'hC3) begin fails++; $display("FAIL clamp_out got=%h exp=c3", v_out[b0]); end
      tests++; if (v_err[b0] !== 1'b0) begin fails++; $display("FAIL clamp_err got=%b exp=0", v_err[b0]); end
      tests++; if (v_cyc[b0] !== r + 76 + SD) begin fails++; $display("FAIL clamp_latency got=%0d exp=%0d", v_cyc[b0], r + 76 + SD); end
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_back_to_back;
    test_coding_err;
    test_preamble;
    test_abort_en;
    test_abort_rst;
    test_en_line_high;
    test_clamp;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
